// File: rtl/uint16_to_uint8_narrower.sv
// Streaming 16-bit to 8-bit width down-converter with optional single-byte
// compaction of words whose upper byte is zero, plus debug word/byte counters.
module uint16_to_uint8_narrower #(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit COMPACT   = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [15:0]      IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [7:0]       OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_LAST,
  output logic             OUT_WIDE,
  output logic [CNT_W-1:0] CNT_WORDS,
  output logic [CNT_W-1:0] CNT_BYTES
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  state_t           r_state;
  logic [15:0]      r_hold;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_out_wide;
  logic [CNT_W-1:0] r_cnt_words;
  logic [CNT_W-1:0] r_cnt_bytes;

  logic             w_in_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_wide_in;
  logic [7:0]       w_first_byte;
  logic [7:0]       w_second_byte;

  // A new word may enter once the final byte of the current one is leaving,
  // which keeps back-to-back compact words bubble-free.
  always_comb begin
    w_in_ready = 1'b0;
    if (!RST) begin
      case (r_state)
        S_IDLE:   w_in_ready = 1'b1;
        S_FIRST,
        S_SECOND: w_in_ready = r_out_last && OUT_READY;
        default:  w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_in_xfer     = IN_VALID && w_in_ready;
  assign w_out_xfer    = r_out_valid && OUT_READY;
  assign w_wide_in     = !COMPACT || (IN_DATA[15:8] != 8'h00);
  assign w_first_byte  = (w_wide_in && MSB_FIRST) ? IN_DATA[15:8] : IN_DATA[7:0];
  assign w_second_byte = MSB_FIRST ? r_hold[7:0] : r_hold[15:8];

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the hold register is explicitly cleared so a word pending at
      // reset can never resurface as a stale second byte.
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_wide  <= 1'b0;
      r_cnt_words <= '0;
      r_cnt_bytes <= '0;
    end else begin
      if (w_out_xfer) begin
        r_cnt_bytes <= r_cnt_bytes + 1'b1;
        if (r_out_last) begin
          r_cnt_words <= r_cnt_words + 1'b1;
        end
      end

      if (w_in_xfer) begin
        r_hold      <= IN_DATA;
        r_state     <= S_FIRST;
        r_out_valid <= 1'b1;
        r_out_data  <= w_first_byte;
        r_out_last  <= !w_wide_in;
        r_out_wide  <= w_wide_in;
      end else if (w_out_xfer) begin
        if (r_state == S_FIRST && !r_out_last) begin
          r_state    <= S_SECOND;
          r_out_data <= w_second_byte;
          r_out_last <= 1'b1;
          r_out_wide <= 1'b1;
        end else begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_wide  <= 1'b0;
        end
      end
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_out_valid;
  assign OUT_LAST  = r_out_last;
  assign OUT_WIDE  = r_out_wide;
  assign CNT_WORDS = r_cnt_words;
  assign CNT_BYTES = r_cnt_bytes;

endmodule
